// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the Selen 5-stage core
// (IF, DEC, EXE, MEM, WB).
//   * Keeps a shadow copy of in-flight destinations for EXE/MEM/WB.
//   * Registers the forwarding selects for the instruction entering EXE.
//   * Holds DEC for LD_STALL bubbles when a source depends on a recent load.
//   * Runs a RUN/FLUSH state machine that kills IF/DEC and DEC/EXE for
//     FLUSH_CYC cycles after a branch/jump redirect.
//   * Freezes all state on an instruction or data cache miss.
//
// Parameters:
//   RIDX_W    register index width
//   LD_STALL  bubbles after a load before a dependent may issue (1 or 2)
//   FLUSH_CYC kill cycles after a redirect (1..7)
//   CNT_W     perf counter width (only with HAZ_PERF_CNT_EN)
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   dec_*_in              instruction currently in DEC (valid, sources,
//                         source-use flags, destination, write, load)
//   exe_redirect_in       branch taken / jump resolved in EXE
//   icache_stall_in       fetch miss
//   dcache_stall_in       MEM miss
//   enb_bus_out[3:0]      pipeline register enables
//                         [0]=IF/DEC [1]=DEC/EXE [2]=EXE/MEM [3]=MEM/WB
//   kill_bus_out[3:0]     pipeline register kills, same indexing
//   pc_stop_out           hold PC
//   issue_out             DEC instruction moves into EXE this cycle
//   fwd_rs1/rs2_sel_out   EXE operand source: 00 regfile, 01 MEM, 10 WB
//   flush_active_out      state machine is in FLUSH
//
// Optional build macro HAZ_PERF_CNT_EN adds saturating counters:
//   perf_lu_cnt_out, perf_flush_cnt_out, perf_cstall_cnt_out (CNT_W each).
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int RIDX_W    = 5,
  parameter int LD_STALL  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid_in,
  input  logic [RIDX_W-1:0] dec_rs1_in,
  input  logic [RIDX_W-1:0] dec_rs2_in,
  input  logic              dec_rs1_use_in,
  input  logic              dec_rs2_use_in,
  input  logic [RIDX_W-1:0] dec_rd_in,
  input  logic              dec_we_in,
  input  logic              dec_ld_in,
  input  logic              exe_redirect_in,
  input  logic              icache_stall_in,
  input  logic              dcache_stall_in,
  output logic [3:0]        enb_bus_out,
  output logic [3:0]        kill_bus_out,
  output logic              pc_stop_out,
  output logic              issue_out,
  output logic [1:0]        fwd_rs1_sel_out,
  output logic [1:0]        fwd_rs2_sel_out,
  output logic              flush_active_out
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_lu_cnt_out,
  output logic [CNT_W-1:0]  perf_flush_cnt_out,
  output logic [CNT_W-1:0]  perf_cstall_cnt_out
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic              v;
    logic              we;
    logic              ld;
    logic [RIDX_W-1:0] rd;
  } shadow_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Counter preload: the redirect cycle itself is the first kill cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t     state, state_next;
  logic [2:0] flush_cnt, flush_cnt_next;

  shadow_t    exe_q, mem_q, wb_q;
  logic [1:0] fwd_rs1_q, fwd_rs2_q;

  logic cstall;
  logic rs1_exe, rs2_exe, rs1_mem, rs2_mem;
  logic lu_stall;
  logic issue;
  logic flush_kill;

  // ---------------------------------------------------------------------------
  // Dependency detection
  // ---------------------------------------------------------------------------
  function automatic logic src_match(input shadow_t              p,
                                     input logic [RIDX_W-1:0]    src,
                                     input logic                 use_src);
    // x0 is hard-wired zero, so a write to it is never a real dependency.
    return p.v && p.we && (p.rd == src) && (src != '0) && use_src;
  endfunction

  // Youngest producer wins. A load still in EXE has no data yet; that case
  // is held back by lu_stall, so it must never select the MEM bypass.
  function automatic logic [1:0] fwd_pick(input logic m_exe,
                                          input logic exe_is_ld,
                                          input logic m_mem);
    if (m_exe && !exe_is_ld) return FWD_MEM;
    else if (m_mem)          return FWD_WB;
    else                     return FWD_RF;
  endfunction

  assign cstall  = icache_stall_in | dcache_stall_in;

  assign rs1_exe = src_match(exe_q, dec_rs1_in, dec_rs1_use_in);
  assign rs2_exe = src_match(exe_q, dec_rs2_in, dec_rs2_use_in);
  assign rs1_mem = src_match(mem_q, dec_rs1_in, dec_rs1_use_in);
  assign rs2_mem = src_match(mem_q, dec_rs2_in, dec_rs2_use_in);

  assign lu_stall = dec_valid_in &
                    (((rs1_exe | rs2_exe) & exe_q.ld) |
                     ((LD_STALL == 2) & (rs1_mem | rs2_mem) & mem_q.ld));

  assign issue = dec_valid_in & ~cstall & ~lu_stall &
                 (state == RUN) & ~exe_redirect_in;

  // Either the redirect cycle itself or a remaining FLUSH cycle.
  assign flush_kill = exe_redirect_in | (state == FLUSH);

  // ---------------------------------------------------------------------------
  // Shadow pipeline and registered forwarding selects
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // stage samples the pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only the valid bits are reset; rd/we/ld are qualified by v and
      // are don't-care while v is low.
      exe_q.v   <= 1'b0;
      mem_q.v   <= 1'b0;
      wb_q.v    <= 1'b0;
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end else if (!cstall) begin
      wb_q     <= mem_q;
      mem_q    <= exe_q;
      exe_q.v  <= issue;
      exe_q.we <= dec_we_in;
      exe_q.ld <= dec_ld_in;
      exe_q.rd <= dec_rd_in;
      fwd_rs1_q <= issue ? fwd_pick(rs1_exe, exe_q.ld, rs1_mem) : FWD_RF;
      fwd_rs2_q <= issue ? fwd_pick(rs2_exe, exe_q.ld, rs2_mem) : FWD_RF;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush state machine: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush state machine: next state
  // ---------------------------------------------------------------------------
  // A redirect raised during a cache stall is held by its source (EXE is
  // frozen), so it is simply taken on the first non-stall cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable; no latches.
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (!cstall) begin
      unique case (state)
        RUN: begin
          if (exe_redirect_in) begin
            flush_cnt_next = FLUSH_LOAD;
            // FLUSH_CYC=1: the redirect cycle is the only kill cycle.
            if (FLUSH_LOAD != 3'd0) state_next = FLUSH;
          end
        end
        FLUSH: begin
          if (exe_redirect_in) begin
            flush_cnt_next = FLUSH_LOAD;
          end else begin
            flush_cnt_next = flush_cnt - 3'd1;
            if (flush_cnt_next == 3'd0) state_next = RUN;
          end
        end
        default: begin
          state_next     = RUN;
          flush_cnt_next = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flush state machine: outputs and pipeline control buses
  // Priority: reset, cache stall, redirect/flush, load-use, normal flow.
  // ---------------------------------------------------------------------------
  always_comb begin
    enb_bus_out      = 4'hF;
    kill_bus_out     = 4'h0;
    pc_stop_out      = 1'b0;
    issue_out        = issue;
    fwd_rs1_sel_out  = fwd_rs1_q;
    fwd_rs2_sel_out  = fwd_rs2_q;
    flush_active_out = (state == FLUSH);

    if (!rst_n) begin
      enb_bus_out      = 4'h0;
      kill_bus_out     = 4'hF;
      pc_stop_out      = 1'b1;
      issue_out        = 1'b0;
      fwd_rs1_sel_out  = FWD_RF;
      fwd_rs2_sel_out  = FWD_RF;
      flush_active_out = 1'b0;
    end else if (cstall) begin
      enb_bus_out  = 4'h0;
      kill_bus_out = 4'h0;
      pc_stop_out  = 1'b1;
    end else if (flush_kill) begin
      // PC keeps running so it can load the redirect target.
      kill_bus_out = 4'b0011;
    end else if (lu_stall) begin
      // Hold IF/DEC and PC, push a bubble into DEC/EXE, let older work drain.
      enb_bus_out  = 4'b1110;
      kill_bus_out = 4'b0010;
      pc_stop_out  = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] lu_cnt, flush_cyc_cnt, cstall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt        <= '0;
      flush_cyc_cnt <= '0;
      cstall_cnt    <= '0;
    end else if (cstall) begin
      cstall_cnt <= sat_inc(cstall_cnt);
    end else begin
      if (lu_stall)   lu_cnt        <= sat_inc(lu_cnt);
      if (flush_kill) flush_cyc_cnt <= sat_inc(flush_cyc_cnt);
    end
  end

  assign perf_lu_cnt_out     = lu_cnt;
  assign perf_flush_cnt_out  = flush_cyc_cnt;
  assign perf_cstall_cnt_out = cstall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. Two instances:
//   dut0: LD_STALL=1, FLUSH_CYC=3
//   dut1: LD_STALL=2, FLUSH_CYC=1
// Each cycle one instance receives a stimulus and the expected outputs for
// that cycle are queued; at the following falling edge the entry is popped
// and compared against the selected instance.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       redir;
    logic       ics;
    logic       dcs;
  } stim_t;

  typedef struct packed {
    logic [3:0] enb;
    logic [3:0] kill;
    logic       pc_stop;
    logic       issue;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       flush;
  } obs_t;

  typedef struct {
    int    sel;
    obs_t  o;
    string tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t st0 = '0;
  stim_t st1 = '0;
  exp_t  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] enb0, kill0, enb1, kill1;
  logic       pc0, iss0, fa0, pc1, iss1, fa1;
  logic [1:0] f1_0, f2_0, f1_1, f2_1;
  obs_t       ob0, ob1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RIDX_W(5), .LD_STALL(1), .FLUSH_CYC(3), .CNT_W(32)) dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid_in     (st0.valid),
    .dec_rs1_in       (st0.rs1),
    .dec_rs2_in       (st0.rs2),
    .dec_rs1_use_in   (st0.u1),
    .dec_rs2_use_in   (st0.u2),
    .dec_rd_in        (st0.rd),
    .dec_we_in        (st0.we),
    .dec_ld_in        (st0.ld),
    .exe_redirect_in  (st0.redir),
    .icache_stall_in  (st0.ics),
    .dcache_stall_in  (st0.dcs),
    .enb_bus_out      (enb0),
    .kill_bus_out     (kill0),
    .pc_stop_out      (pc0),
    .issue_out        (iss0),
    .fwd_rs1_sel_out  (f1_0),
    .fwd_rs2_sel_out  (f2_0),
    .flush_active_out (fa0)
  );

  hazard_scoreboard #(.RIDX_W(5), .LD_STALL(2), .FLUSH_CYC(1), .CNT_W(32)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid_in     (st1.valid),
    .dec_rs1_in       (st1.rs1),
    .dec_rs2_in       (st1.rs2),
    .dec_rs1_use_in   (st1.u1),
    .dec_rs2_use_in   (st1.u2),
    .dec_rd_in        (st1.rd),
    .dec_we_in        (st1.we),
    .dec_ld_in        (st1.ld),
    .exe_redirect_in  (st1.redir),
    .icache_stall_in  (st1.ics),
    .dcache_stall_in  (st1.dcs),
    .enb_bus_out      (enb1),
    .kill_bus_out     (kill1),
    .pc_stop_out      (pc1),
    .issue_out        (iss1),
    .fwd_rs1_sel_out  (f1_1),
    .fwd_rs2_sel_out  (f2_1),
    .flush_active_out (fa1)
  );

  assign ob0 = {enb0, kill0, pc0, iss0, f1_0, f2_0, fa0};
  assign ob1 = {enb1, kill1, pc1, iss1, f1_1, f2_1, fa1};

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus and expectation builders
  // ---------------------------------------------------------------------------
  function automatic stim_t ins(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic we, input logic ld);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rs1   = rs1;
    s.u1    = u1;
    s.rs2   = rs2;
    s.u2    = u2;
    s.rd    = rd;
    s.we    = we;
    s.ld    = ld;
    return s;
  endfunction

  function automatic stim_t ctl(input stim_t s, input logic redir,
                                input logic ics, input logic dcs);
    stim_t r;
    r       = s;
    r.redir = redir;
    r.ics   = ics;
    r.dcs   = dcs;
    return r;
  endfunction

  function automatic obs_t ex(input logic [3:0] enb, input logic [3:0] kill,
                              input logic pc, input logic iss,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input logic fl);
    obs_t o;
    o.enb     = enb;
    o.kill    = kill;
    o.pc_stop = pc;
    o.issue   = iss;
    o.f1      = f1;
    o.f2      = f2;
    o.flush   = fl;
    return o;
  endfunction

  // Normal flow, load-use bubble, cache stall, redirect/flush kill, reset.
  function automatic obs_t run(input logic iss, input logic [1:0] f1, input logic [1:0] f2);
    return ex(4'hF, 4'h0, 1'b0, iss, f1, f2, 1'b0);
  endfunction
  function automatic obs_t lus(input logic [1:0] f1, input logic [1:0] f2);
    return ex(4'hE, 4'h2, 1'b1, 1'b0, f1, f2, 1'b0);
  endfunction
  function automatic obs_t cst(input logic [1:0] f1, input logic [1:0] f2, input logic fl);
    return ex(4'h0, 4'h0, 1'b1, 1'b0, f1, f2, fl);
  endfunction
  function automatic obs_t kil(input logic [1:0] f1, input logic [1:0] f2, input logic fl);
    return ex(4'hF, 4'h3, 1'b0, 1'b0, f1, f2, fl);
  endfunction
  function automatic obs_t rst_o();
    return ex(4'h0, 4'hF, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
  endfunction

  // One clock cycle: drive after the rising edge, queue the expectation,
  // then pop and compare at the falling edge.
  task automatic cyc(input int sel, input stim_t s, input obs_t e, input string tag);
    exp_t item;
    exp_t head;
    obs_t o;
    @(posedge clk);
    #1;
    st0 = (sel == 0) ? s : '0;
    st1 = (sel == 1) ? s : '0;
    item.sel = sel;
    item.o   = e;
    item.tag = tag;
    exp_q.push_back(item);
    @(negedge clk);
    head = exp_q.pop_front();
    o    = (head.sel == 0) ? ob0 : ob1;
    check({head.tag, ".enb"},   32'(o.enb),     32'(head.o.enb));
    check({head.tag, ".kill"},  32'(o.kill),    32'(head.o.kill));
    check({head.tag, ".pc"},    32'(o.pc_stop), 32'(head.o.pc_stop));
    check({head.tag, ".issue"}, 32'(o.issue),   32'(head.o.issue));
    check({head.tag, ".fwd"},   32'({o.f1, o.f2}), 32'({head.o.f1, head.o.f2}));
    check({head.tag, ".flush"}, 32'(o.flush),   32'(head.o.flush));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    stim_t dep;

    // Reset held: outputs forced even with a valid instruction in DEC.
    cyc(0, ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), rst_o(), "rst_d0");
    cyc(1, ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), rst_o(), "rst_d1");
    rst_n = 1'b1;

    // Back-to-back dependent ALU: x5 <= x1+x2 ; x6 <= x5+x5.
    cyc(0, ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "b2b_p");
    cyc(0, ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "b2b_c");
    cyc(0, '0, run(1'b0, 2'b01, 2'b01), "b2b_fwd");

    // Load to x0 followed by a reader of x0: no stall, no bypass.
    cyc(0, ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "x0_p");
    cyc(0, ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "x0_c");
    cyc(0, '0, run(1'b0, 2'b00, 2'b00), "x0_fwd");

    // Load-use with LD_STALL=1: one bubble, then bypass from WB.
    cyc(0, ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "lu1_ld");
    dep = ins(5'd7, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc(0, dep, lus(2'b00, 2'b00), "lu1_bub");
    cyc(0, dep, run(1'b1, 2'b00, 2'b00), "lu1_iss");
    cyc(0, '0, run(1'b0, 2'b10, 2'b00), "lu1_fwd");

    // Redirect with FLUSH_CYC=3: three kill cycles, two in FLUSH.
    dep = ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    cyc(0, ctl(dep, 1'b1, 1'b0, 1'b0), kil(2'b00, 2'b00, 1'b0), "fl_redir");
    cyc(0, dep, kil(2'b00, 2'b00, 1'b1), "fl_1");
    cyc(0, dep, kil(2'b00, 2'b00, 1'b1), "fl_2");
    cyc(0, ins(5'd10, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "fl_run");

    // Data-cache miss coincident with redirect and a load-use hazard.
    cyc(0, ins(5'd12, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "cs_ld");
    dep = ins(5'd11, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(0, ctl(dep, 1'b1, 1'b0, 1'b1), cst(2'b01, 2'b00, 1'b0), $sformatf("cs_hold%0d", i));
    cyc(0, ctl(dep, 1'b1, 1'b0, 1'b0), kil(2'b01, 2'b00, 1'b0), "cs_redir");
    cyc(0, '0, kil(2'b00, 2'b00, 1'b1), "cs_fl1");
    cyc(0, '0, kil(2'b00, 2'b00, 1'b1), "cs_fl2");
    cyc(0, dep, run(1'b1, 2'b00, 2'b00), "cs_run");

    // Instruction-cache miss keeps the load frozen in EXE.
    cyc(0, ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "ic_ld");
    dep = ins(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    cyc(0, ctl(dep, 1'b0, 1'b1, 1'b0), cst(2'b00, 2'b00, 1'b0), "ic_hold0");
    cyc(0, ctl(dep, 1'b0, 1'b1, 1'b0), cst(2'b00, 2'b00, 1'b0), "ic_hold1");
    cyc(0, dep, lus(2'b00, 2'b00), "ic_bub");
    cyc(0, dep, run(1'b1, 2'b00, 2'b00), "ic_iss");
    cyc(0, '0, run(1'b0, 2'b10, 2'b00), "ic_fwd");

    // Reset asserted in the middle of FLUSH with a load still in flight.
    cyc(0, ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "mr_ld");
    cyc(0, ctl('0, 1'b1, 1'b0, 1'b0), kil(2'b00, 2'b00, 1'b0), "mr_redir");
    rst_n = 1'b0;
    dep = ins(5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
    cyc(0, dep, rst_o(), "mr_rst");
    rst_n = 1'b1;
    cyc(0, dep, run(1'b1, 2'b00, 2'b00), "mr_run");
    cyc(0, ins(5'd16, 1'b1, 5'd15, 1'b1, 5'd17, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "mr_dep");
    cyc(0, '0, run(1'b0, 2'b01, 2'b00), "mr_fwd");

    // LD_STALL=2: two bubbles, then no bypass (producer already in WB).
    cyc(1, ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1), run(1'b1, 2'b00, 2'b00), "lu2_ld");
    dep = ins(5'd7, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc(1, dep, lus(2'b00, 2'b00), "lu2_bub0");
    cyc(1, dep, lus(2'b00, 2'b00), "lu2_bub1");
    cyc(1, dep, run(1'b1, 2'b00, 2'b00), "lu2_iss");
    cyc(1, '0, run(1'b0, 2'b00, 2'b00), "lu2_fwd");

    // FLUSH_CYC=1: a single kill cycle without entering FLUSH.
    cyc(1, ctl(ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0),
        kil(2'b00, 2'b00, 1'b0), "fc1_redir");
    cyc(1, ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0), run(1'b1, 2'b00, 2'b00), "fc1_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
